// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the nibble-serial add/subtract sequencer of the
// Lab-8 ALU: opcode encodings, slice width and the controller state type.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  // Opcode encodings. OP_SUB doubles as the initial carry (the "+1" of A + ~B + 1).
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of the shared add/sub slice.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage : alu_pkg

// File: rtl/nibble_addsub.sv
// ---------------------------------------------------------------------------
// nibble_addsub
// The single shared 4-bit adder slice. Subtraction is done by the caller,
// which inverts B and supplies the initial carry.
// Ports:
//   A, B  in  4  slice operands
//   Cin   in  1  carry into bit 0
//   S     out 4  slice sum
//   Cout  out 1  carry out of bit 3
//   C3    out 1  carry into bit 3 (used for signed overflow on the top nibble)
// ---------------------------------------------------------------------------
module nibble_addsub
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Cin,
  output logic [NIB_W-1:0] S,
  output logic             Cout,
  output logic             C3
);

  // Split at bit 3 so the carry into the sign position of the slice is
  // available directly instead of being reconstructed from the sum.
  logic [NIB_W-1:0] lowSum;  // bits [2:0] of the sum plus carry into bit 3
  logic [1:0]       topSum;  // bit 3 of the sum plus carry out

  assign lowSum = {1'b0, A[2:0]} + {1'b0, B[2:0]} + {3'b000, Cin};
  assign topSum = {1'b0, A[3]} + {1'b0, B[3]} + {1'b0, lowSum[3]};

  assign S    = {topSum[0], lowSum[2:0]};
  assign C3   = lowSum[3];
  assign Cout = topSum[1];

endmodule : nibble_addsub

// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
// Nibble-serial add/subtract sequencer. Accepts WIDTH-bit operands and an
// ADD/SUB opcode through a start/ready handshake, then runs one shared 4-bit
// slice over WIDTH/4 cycles, least-significant nibble first. Result and flags
// are committed together on the edge that processes the last nibble.
// Parameters:
//   WIDTH       operand/result width; multiple of 4, at least 8
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous active-low reset
//   start       in   1      request, accepted only while ready=1
//   op          in   1      0=ADD, 1=SUB (a-b)
//   a, b        in   WIDTH  operands, sampled on the accept edge
//   ready       out  1      high in IDLE
//   busy        out  1      high in RUN
//   done        out  1      one-cycle pulse in DONE
//   result      out  WIDTH  sum/difference, held until the next completion
//   cout        out  1      ADD: carry out; SUB: borrow
//   zero        out  1      result == 0
//   neg         out  1      result MSB
//   ovf         out  1      signed overflow
// ---------------------------------------------------------------------------
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int N      = WIDTH / NIB_W;
  localparam int CNT_W  = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  stateT            state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             opReg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] resultWork;

  logic [NIB_W-1:0] nibA;
  logic [NIB_W-1:0] nibB;
  logic [NIB_W-1:0] nibSum;
  logic             nibCout;
  logic             nibC3;
  logic [WIDTH-1:0] workNext;

  // Slice inputs: current nibble of each operand, B inverted for SUB.
  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here a default first), otherwise synthesis infers a latch.
  always_comb begin
    nibA = opA[cnt*NIB_W +: NIB_W];
    nibB = opB[cnt*NIB_W +: NIB_W] ^ {NIB_W{opReg}};
  end

  nibble_addsub uSlice (
    .A    (nibA),
    .B    (nibB),
    .Cin  (carry),
    .S    (nibSum),
    .Cout (nibCout),
    .C3   (nibC3)
  );

  // Working result with the current nibble merged in. On the last nibble this
  // is the complete result, which lets result and flags commit on that edge.
  always_comb begin
    workNext = resultWork;
    workNext[cnt*NIB_W +: NIB_W] = nibSum;
  end

  // Controller: FSM, datapath registers and registered handshake outputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      opA        <= '0;
      opB        <= '0;
      opReg      <= OP_ADD;
      carry      <= 1'b0;
      cnt        <= '0;
      resultWork <= '0;
      result     <= '0;
      cout       <= 1'b0;
      zero       <= 1'b1;
      neg        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            opA   <= a;
            opB   <= b;
            opReg <= op;
            carry <= op;  // SUB injects the +1 of two's complement here
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          resultWork <= workNext;
          carry      <= nibCout;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= workNext;
            // Final carry is "no borrow" for SUB, so flip it to report borrow.
            cout   <= nibCout ^ opReg;
            zero   <= (workNext == '0);
            neg    <= workNext[WIDTH-1];
            ovf    <= nibC3 ^ nibCout;
          end
        end

        DONE: begin
          // start is ignored here; the request is not queued.
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : alu_serial_ctrl

// File: tb/tb_alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_ctrl
// Self-checking bench for alu_serial_ctrl. Instantiates a 16-bit and an
// 8-bit copy, drives directed and random operations, and compares against an
// arithmetic reference model (plain integer add/subtract and sign rules).
// ---------------------------------------------------------------------------
module tb_alu_serial_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  // 16-bit instance
  logic        start16, op16;
  logic [15:0] a16, b16, result16;
  logic        ready16, busy16, done16, cout16, zero16, neg16, ovf16;

  // 8-bit instance
  logic        start8, op8;
  logic [7:0]  a8, b8, result8;
  logic        ready8, busy8, done8, cout8, zero8, neg8, ovf8;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .result(result16),
    .cout(cout16), .zero(zero16), .neg(neg16), .ovf(ovf16)
  );

  alu_serial_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .result(result8),
    .cout(cout8), .zero(zero8), .neg(neg8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain modular arithmetic plus sign rules for overflow.
  task automatic model(input int w, input logic o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic co, output logic z,
                       output logic n, output logic v);
    int unsigned m, xa, ya, s;
    logic sx, sy, sr;
    m  = (32'd1 << w) - 1;
    xa = 32'(x) & m;
    ya = 32'(y) & m;
    if (o == 1'b0) begin
      s  = xa + ya;
      co = ((s >> w) & 1) != 0;
    end else begin
      s  = xa - ya;
      co = (xa < ya);
    end
    s  = s & m;
    r  = 16'(s);
    sx = ((xa >> (w - 1)) & 1) != 0;
    sy = ((ya >> (w - 1)) & 1) != 0;
    sr = ((s  >> (w - 1)) & 1) != 0;
    z  = (s == 0);
    n  = sr;
    v  = (o == 1'b0) ? ((sx == sy) && (sr != sx)) : ((sx != sy) && (sr != sx));
  endtask

  task automatic drive(input bit narrow, input logic s, input logic o,
                       input logic [15:0] x, input logic [15:0] y);
    if (narrow) begin
      start8 = s; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start16 = s; op16 = o; a16 = x; b16 = y;
    end
  endtask

  function automatic logic outReady(bit narrow);
    return narrow ? ready8 : ready16;
  endfunction
  function automatic logic outBusy(bit narrow);
    return narrow ? busy8 : busy16;
  endfunction
  function automatic logic outDone(bit narrow);
    return narrow ? done8 : done16;
  endfunction
  function automatic logic [19:0] outBundle(bit narrow);
    // {result, cout, zero, neg, ovf}
    if (narrow) return {8'h00, result8, cout8, zero8, neg8, ovf8};
    return {result16, cout16, zero16, neg16, ovf16};
  endfunction

  task automatic checkBundle(input string tag, input int w, input logic o,
                             input logic [15:0] x, input logic [15:0] y,
                             input logic [19:0] got);
    logic [15:0] r;
    logic co, z, n, v;
    model(w, o, x, y, r, co, z, n, v);
    check({tag, ":result"}, 32'(got[19:4]), 32'(r));
    check({tag, ":cout"},   32'(got[3]),    32'(co));
    check({tag, ":zero"},   32'(got[2]),    32'(z));
    check({tag, ":neg"},    32'(got[1]),    32'(n));
    check({tag, ":ovf"},    32'(got[0]),    32'(v));
  endtask

  // One complete operation with latency, busy-length and pulse-width checks.
  task automatic runOp(input bit narrow, input logic o, input logic [15:0] x,
                       input logic [15:0] y, input string tag);
    int n, w, doneAt, doneN, busyN, waitC;
    logic [19:0] got;
    n = narrow ? 2 : 4;
    w = narrow ? 8 : 16;
    doneAt = 0; doneN = 0; busyN = 0; waitC = 0;
    got = '0;
    @(negedge clk);
    while (!outReady(narrow) && waitC < 20) begin
      @(negedge clk);
      waitC++;
    end
    check({tag, ":ready_before"}, 32'(outReady(narrow)), 32'd1);
    drive(narrow, 1'b1, o, x, y);
    @(posedge clk);  // accept edge k
    #1;
    // Scramble inputs: the operation in flight must not see them.
    drive(narrow, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);  // after edge k+c-1
      if (outBusy(narrow)) busyN++;
      if (outDone(narrow)) begin
        doneN++;
        if (doneAt == 0) begin
          doneAt = c;
          got = outBundle(narrow);
        end
      end
    end
    check({tag, ":done_latency"}, 32'(doneAt - 1), 32'(n));
    check({tag, ":busy_cycles"},  32'(busyN), 32'(n));
    check({tag, ":done_pulses"},  32'(doneN), 32'd1);
    check({tag, ":ready_after"},  32'(outReady(narrow)), 32'd1);
    checkBundle(tag, w, o, x, y, got);
  endtask

  typedef struct {
    bit          narrow;
    logic        o;
    logic [15:0] x;
    logic [15:0] y;
    string       tag;
  } vecT;

  vecT dirVecs[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] x1, y1, x2, y2;
    logic        o1, o2;
    logic [19:0] got;
    int readyAt, readyN, doneN;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst16:ready",  32'(ready16), 32'd1);
    check("rst16:busy",   32'(busy16),  32'd0);
    check("rst16:done",   32'(done16),  32'd0);
    check("rst16:bundle", 32'(outBundle(1'b0)), 32'h0_0004);
    check("rst8:ready",   32'(ready8),  32'd1);
    check("rst8:bundle",  32'(outBundle(1'b1)), 32'h0_0004);
    rst_n = 1'b1;

    // Directed vectors
    dirVecs.push_back('{1'b0, 1'b0, 16'h1234, 16'h0FFF, "add_1234_0fff"});
    dirVecs.push_back('{1'b0, 1'b0, 16'hFFFF, 16'h0001, "add_ffff_0001"});
    dirVecs.push_back('{1'b0, 1'b0, 16'h7FFF, 16'h0001, "add_7fff_0001"});
    dirVecs.push_back('{1'b0, 1'b1, 16'h0005, 16'h0007, "sub_0005_0007"});
    dirVecs.push_back('{1'b0, 1'b1, 16'h8000, 16'h0001, "sub_8000_0001"});
    dirVecs.push_back('{1'b0, 1'b1, 16'h4321, 16'h4321, "sub_equal"});
    dirVecs.push_back('{1'b1, 1'b0, 16'h00F0, 16'h0010, "w8_add_f0_10"});
    dirVecs.push_back('{1'b1, 1'b1, 16'h0080, 16'h0001, "w8_sub_80_01"});
    dirVecs.push_back('{1'b1, 1'b0, 16'h007F, 16'h0001, "w8_add_7f_01"});
    foreach (dirVecs[i])
      runOp(dirVecs[i].narrow, dirVecs[i].o, dirVecs[i].x, dirVecs[i].y, dirVecs[i].tag);

    // Back-to-back with start held high and operands changing during RUN.
    x1 = 16'($urandom); y1 = 16'($urandom); o1 = 1'($urandom);
    x2 = 16'($urandom); y2 = 16'($urandom); o2 = 1'($urandom);
    readyAt = 0; readyN = 0; got = '0;
    @(negedge clk);
    drive(1'b0, 1'b1, o1, x1, y1);
    @(posedge clk);  // accept edge k
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);  // after edge k+c-1
      if (ready16) begin
        readyN++;
        if (readyAt == 0) readyAt = c;
      end
      if (c == 5) got = outBundle(1'b0);
      if (c == 6) drive(1'b0, 1'b1, o2, x2, y2);
      else        drive(1'b0, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
    end
    check("b2b:ready_at", 32'(readyAt), 32'd6);
    check("b2b:ready_cnt", 32'(readyN), 32'd1);
    checkBundle("b2b_first", 16, o1, x1, y1, got);
    @(posedge clk);  // second accept edge k+6
    #1;
    drive(1'b0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    doneN = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (done16) begin
        doneN++;
        got = outBundle(1'b0);
      end
    end
    check("b2b:second_done", 32'(doneN), 32'd1);
    checkBundle("b2b_second", 16, o2, x2, y2, got);

    // Reset in the middle of RUN (cnt == 2) aborts without a done pulse.
    runOp(1'b0, 1'b0, 16'h1111, 16'h2222, "pre_reset");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h0101);
    @(posedge clk);  // accept edge k
    #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    doneN = 0;
    repeat (3) begin
      @(negedge clk);
      if (done16) doneN++;
    end
    rst_n = 1'b0;    // sampled at edge k+3
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst:done",  32'(done16),  32'd0);
    check("midrst:ready", 32'(ready16), 32'd1);
    check("midrst:busy",  32'(busy16),  32'd0);
    check("midrst:bundle", 32'(outBundle(1'b0)), 32'h0_0004);
    repeat (6) begin
      @(negedge clk);
      if (done16) doneN++;
    end
    check("midrst:no_done", 32'(doneN), 32'd0);
    runOp(1'b0, 1'b0, 16'h0001, 16'h0001, "post_reset_add");

    // Random operations on both widths
    for (int i = 0; i < 40; i++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) == 0);
      runOp(narrow, 1'($urandom), 16'($urandom), 16'($urandom), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_alu_serial_ctrl

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Nibble-serial add/subtract sequencer for the Lab-8 ALU. It accepts WIDTH-bit operands and an ADD/SUB opcode through a start/ready handshake. It then drives one shared 4-bit add/sub slice over WIDTH/4 consecutive cycles, least-significant nibble first, and registers the result and flags. It sits between the ALU's operand/opcode registers and the result/flag outputs, replacing a full-width combinational adder.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; accepted only when ready=1
- op  in  1  0=ADD, 1=SUB (A−B)
- a  in  WIDTH  operand A, sampled on the accept edge
- b  in  WIDTH  operand B, sampled on the accept edge
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- result  out  WIDTH  sum/difference; held until the next completed operation
- cout  out  1  ADD: carry out; SUB: borrow (final carry XOR op)
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states:
  - IDLE: ready=1. On start=1 → RUN. The edge latches a, b and op, sets carry←op and cnt←0. The result and flag outputs are not touched.
  - RUN: each cycle computes nibble cnt. The inputs are a_nib, b_nib XOR {4{op}} and carry. The 4-bit sum is written into result_work[4·cnt+3:4·cnt], and carry takes the nibble carry out. The carry into bit 3 of the last nibble is captured for ovf. cnt increments. When cnt == WIDTH/4−1, the state goes to DONE on that same edge.
  - DONE: done=1 for exactly one cycle, then unconditionally → IDLE.
- Result commit: result, cout, zero, neg and ovf are updated together on the edge that processes the last nibble. Partial sums are never visible on result.
- Any start seen while in RUN or DONE is ignored. It is not queued.
- a, b and op may change freely after the accept edge without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH. SUB is A + ~B + 1, with the +1 injected as the initial carry.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, ready=1, busy=0, done=0
  - result=0, cout=0, zero=1, neg=0, ovf=0
  - internal carry and cnt cleared
- Reset during RUN or DONE aborts the operation: no done pulse, and result/flags go to the reset values.
- Latency:
  - Accept edge k.
  - Nibbles 0..N−1 are processed at edges k+1..k+N, where N=WIDTH/4.
  - done=1 and valid result/flags appear in the cycle after edge k+N.
  - ready returns after edge k+N+1.
- Throughput: one operation per N+2 cycles. Back-to-back is allowed with start held high continuously; the next accept occurs at edge k+N+2.
- busy=1 exactly N cycles per operation.

## Structure
- Package alu_pkg holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1
  - NIB_W=4
  - state enum {IDLE, RUN, DONE}
- Sub-module nibble_addsub (A[3:0], B[3:0], Cin, S[3:0], Cout, C3) is the single shared 4-bit slice. C3 is the carry into bit 3, needed for ovf. It is instantiated once.
- The controller holds the FSM, a cnt register of width clog2(N), the carry flop, the operand registers and the result/flag registers. Nibble selection uses indexed part-select.

## Test plan
- ADD 0x1234 + 0x0FFF → result=0x2233, cout=0, zero=0, neg=0, ovf=0. done arrives exactly 4 cycles after the accept edge, and busy is high for 4 cycles.
- ADD 0xFFFF + 0x0001 → result=0x0000, cout=1, zero=1, ovf=0. ADD 0x7FFF + 0x0001 → result=0x8000, ovf=1, neg=1, cout=0.
- SUB 0x0005 − 0x0007 → result=0xFFFE, cout(borrow)=1, neg=1, ovf=0. SUB 0x8000 − 0x0001 → result=0x7FFF, ovf=1, cout=0.
- Hold start=1 with changing a/b during RUN. Only the first operand pair is computed. The second accept occurs at edge k+6 (ready=1 in between), and both results are correct.
- Assert rst_n=0 for one edge while cnt=2 → no done pulse, result=0, zero=1, ready=1. A subsequent ADD 0x0001 + 0x0001 → 0x0002.
- With WIDTH=8: ADD 0xF0 + 0x10 → result=0x00, cout=1, zero=1. done arrives 2 cycles after accept.
